vga_bounce_engine: RTL and testbench

Parametrised, frame-synchronous motion controller for one bouncing sprite on the VGA raster. It replaces the free-running cycle-count animator with several changes:
- moves are paced by `frame_tick`, so motion is tear-free;
- step size and frame divider are runtime inputs;
- hits are clamped to the bounds instead of overshooting;
- run/freeze control, a position-load handshake and per-axis hit pulses are added.

It sits between `hvsync_generator`, which supplies `frame_tick`, and the pixel renderer, which consumes `pos_x`/`pos_y`.

---
 rtl/vga_anim_pkg.sv | 32 +++
 rtl/bounce_axis.sv | 98 +++++++++
 rtl/vga_bounce_engine.sv | 154 +++++++++++++++
 tb/tb_vga_bounce_engine.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_anim_pkg.sv
// rtl/vga_anim_pkg.sv - shared types, default raster constants and clamp helper for the sprite animator
//
// Contents:
//   anim_state_t  : engine state (IDLE after reset, RUN animating, HOLD frozen)
//   DEF_*         : default active resolution and sprite margin
//   clamp_coord() : clamp a coordinate into an inclusive [lo,hi] window
package vga_anim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } anim_state_t;

    localparam int unsigned DEF_H_RES  = 640;
    localparam int unsigned DEF_V_RES  = 480;
    localparam int unsigned DEF_MARGIN = 100;

    function automatic int unsigned clamp_coord(
        input int unsigned v,
        input int unsigned lo,
        input int unsigned hi
    );
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/bounce_axis.sv
// rtl/bounce_axis.sv - one axis of the bouncing sprite: position, direction, reflect and hit pulse
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   step       : apply one step of size speed this cycle
//   load       : take load_val (clamped into [MIN_POS,MAX_POS]) as new position
//   speed      : pixels per step
//   load_val   : requested position
//   pos        : registered axis position (CENTRE after reset)
//   dir        : 1 = moving towards MAX_POS
//   hit        : one-cycle pulse when this axis reflected on the last step
module bounce_axis
    import vga_anim_pkg::*;
#(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned SPEED_W = 4,
    parameter int unsigned MIN_POS = 100,
    parameter int unsigned MAX_POS = 540,
    parameter int unsigned CENTRE  = 320
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    input  logic               load,
    input  logic [SPEED_W-1:0] speed,
    input  logic [COORD_W-1:0] load_val,
    output logic [COORD_W-1:0] pos,
    output logic               dir,
    output logic               hit
);

    localparam logic [COORD_W:0]   MIN_W    = (COORD_W+1)'(MIN_POS);
    localparam logic [COORD_W:0]   MAX_W    = (COORD_W+1)'(MAX_POS);
    localparam logic [COORD_W-1:0] MIN_C    = COORD_W'(MIN_POS);
    localparam logic [COORD_W-1:0] MAX_C    = COORD_W'(MAX_POS);
    localparam logic [COORD_W-1:0] CENTRE_C = COORD_W'(CENTRE);

    // One extra bit so pos+speed near the top of the range cannot wrap
    // before it is compared against the bound.
    logic [COORD_W:0]   pos_w;
    logic [COORD_W:0]   spd_w;
    logic [COORD_W:0]   sum_w;
    logic [COORD_W:0]   floor_w;
    logic [COORD_W-1:0] load_clamped;

    logic [COORD_W-1:0] step_pos;
    logic               step_dir;
    logic               step_hit;

    assign pos_w        = {1'b0, pos};
    assign spd_w        = (COORD_W+1)'(speed);
    assign sum_w        = pos_w + spd_w;
    assign floor_w      = MIN_W + spd_w;
    assign load_clamped = COORD_W'(clamp_coord(32'(load_val), MIN_POS, MAX_POS));

    // Reaching a bound exactly counts as a hit, so with speed 0 a sprite
    // parked on a bound still reflects.
    always_comb begin
        step_pos = pos;
        step_dir = dir;
        step_hit = 1'b0;
        if (dir) begin
            if (sum_w >= MAX_W) begin
                step_pos = MAX_C;
                step_dir = 1'b0;
                step_hit = 1'b1;
            end else begin
                step_pos = sum_w[COORD_W-1:0];
            end
        end else begin
            if (pos_w <= floor_w) begin
                step_pos = MIN_C;
                step_dir = 1'b1;
                step_hit = 1'b1;
            end else begin
                step_pos = pos - spd_w[COORD_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= CENTRE_C;
            dir <= 1'b1;
            hit <= 1'b0;
        end else begin
            hit <= 1'b0;
            if (step) begin
                pos <= step_pos;
                dir <= step_dir;
                hit <= step_hit;
            end else if (load) begin
                pos <= load_clamped;
            end
        end
    end

endmodule

// File: rtl/vga_bounce_engine.sv
// rtl/vga_bounce_engine.sv - frame-paced bouncing sprite controller with run/freeze and position load
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   frame_tick     : once-per-frame pulse; only its rising edge counts
//   run            : 1 = animate, 0 = freeze
//   speed          : pixels moved per step on each axis
//   frame_div      : step once every frame_div+1 frames
//   load_valid     : position-load request, taken when load_ready is high
//   load_x, load_y : requested position, clamped into the bounds
//   load_ready     : high in IDLE and HOLD
//   pos_x, pos_y   : sprite centre
//   dir_x, dir_y   : 1 = increasing coordinate
//   hit_x, hit_y   : one-cycle pulse when that axis reflected
//   step_done      : one-cycle pulse for every applied step
module vga_bounce_engine
    import vga_anim_pkg::*;
#(
    parameter int unsigned H_RES   = DEF_H_RES,
    parameter int unsigned V_RES   = DEF_V_RES,
    parameter int unsigned MARGIN  = DEF_MARGIN,
    parameter int unsigned COORD_W = 10,
    parameter int unsigned SPEED_W = 4,
    parameter int unsigned DIV_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               run,
    input  logic [SPEED_W-1:0] speed,
    input  logic [DIV_W-1:0]   frame_div,
    input  logic               load_valid,
    input  logic [COORD_W-1:0] load_x,
    input  logic [COORD_W-1:0] load_y,
    output logic               load_ready,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               dir_x,
    output logic               dir_y,
    output logic               hit_x,
    output logic               hit_y,
    output logic               step_done
);

    localparam int unsigned X_MIN = MARGIN;
    localparam int unsigned X_MAX = H_RES - MARGIN;
    localparam int unsigned Y_MIN = MARGIN;
    localparam int unsigned Y_MAX = V_RES - MARGIN;

    anim_state_t      state;
    anim_state_t      state_nxt;
    logic [DIV_W-1:0] frame_cnt;
    logic [DIV_W-1:0] frame_cnt_nxt;
    logic             tick_d;
    logic             tick_rise;
    logic             step_fire;
    logic             load_fire;

    // A frame_tick held high for several cycles must produce a single step.
    assign tick_rise = frame_tick & ~tick_d;
    assign load_fire = load_valid & load_ready;

    // The step decision uses the current state, so a due tick arriving in
    // the same cycle that run falls is still applied before entering HOLD.
    always_comb begin
        state_nxt     = state;
        frame_cnt_nxt = frame_cnt;
        step_fire     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_nxt     = ST_RUN;
                    frame_cnt_nxt = '0;
                end
            end
            ST_RUN: begin
                if (tick_rise) begin
                    // >= lets a lowered divider take effect on the next tick.
                    if (frame_cnt >= frame_div) begin
                        step_fire     = 1'b1;
                        frame_cnt_nxt = '0;
                    end else begin
                        frame_cnt_nxt = frame_cnt + DIV_W'(1);
                    end
                end
                if (!run) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // frame_cnt is kept so the divider resumes where it stopped.
                if (run) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            frame_cnt  <= '0;
            tick_d     <= 1'b0;
            step_done  <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state      <= state_nxt;
            frame_cnt  <= frame_cnt_nxt;
            tick_d     <= frame_tick;
            step_done  <= step_fire;
            load_ready <= (state_nxt != ST_RUN);
        end
    end

    bounce_axis #(
        .COORD_W (COORD_W),
        .SPEED_W (SPEED_W),
        .MIN_POS (X_MIN),
        .MAX_POS (X_MAX),
        .CENTRE  (H_RES / 2)
    ) u_axis_x (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (step_fire),
        .load     (load_fire),
        .speed    (speed),
        .load_val (load_x),
        .pos      (pos_x),
        .dir      (dir_x),
        .hit      (hit_x)
    );

    bounce_axis #(
        .COORD_W (COORD_W),
        .SPEED_W (SPEED_W),
        .MIN_POS (Y_MIN),
        .MAX_POS (Y_MAX),
        .CENTRE  (V_RES / 2)
    ) u_axis_y (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (step_fire),
        .load     (load_fire),
        .speed    (speed),
        .load_val (load_y),
        .pos      (pos_y),
        .dir      (dir_y),
        .hit      (hit_y)
    );

endmodule

// File: tb/tb_vga_bounce_engine.sv
// tb/tb_vga_bounce_engine.sv - self-checking bench for vga_bounce_engine
module tb_vga_bounce_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic       run;
    logic [3:0] speed;
    logic [3:0] frame_div;
    logic       load_valid;
    logic [9:0] load_x;
    logic [9:0] load_y;
    logic       load_ready;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       dir_x;
    logic       dir_y;
    logic       hit_x;
    logic       hit_y;
    logic       step_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vga_bounce_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .run        (run),
        .speed      (speed),
        .frame_div  (frame_div),
        .load_valid (load_valid),
        .load_x     (load_x),
        .load_y     (load_y),
        .load_ready (load_ready),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .dir_x      (dir_x),
        .dir_y      (dir_y),
        .hit_x      (hit_x),
        .hit_y      (hit_y),
        .step_done  (step_done)
    );

    // {pos_x, pos_y, dir_x, dir_y, hit_x, hit_y, step_done, load_ready}
    logic [25:0] obs;
    assign obs = {pos_x, pos_y, dir_x, dir_y, hit_x, hit_y, step_done, load_ready};

    typedef struct {
        logic       rst;
        logic       run;
        logic [3:0] speed;
        logic [3:0] div;
        logic       ld;
        logic [9:0] lx;
        logic [9:0] ly;
        logic       tick;
        logic [25:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [25:0] sb[$];

    function automatic logic [25:0] pack_exp(input int x, input int y, input int dx, input int dy,
                                             input int hx, input int hy, input int st, input int rdy);
        return {10'(x), 10'(y), 1'(dx), 1'(dy), 1'(hx), 1'(hy), 1'(st), 1'(rdy)};
    endfunction

    function automatic vec_t mk(input int rst, input int r, input int spd, input int dv,
                                input int ld, input int lx, input int ly, input int tk,
                                input logic [25:0] e);
        vec_t v;
        v.rst   = 1'(rst);
        v.run   = 1'(r);
        v.speed = 4'(spd);
        v.div   = 4'(dv);
        v.ld    = 1'(ld);
        v.lx    = 10'(lx);
        v.ly    = 10'(ly);
        v.tick  = 1'(tk);
        v.exp   = e;
        return v;
    endfunction

    function automatic string fmt(input logic [25:0] v);
        return $sformatf("pos=(%0d,%0d) dir=(%b,%b) hit=(%b,%b) step=%b ready=%b",
                         v[25:16], v[15:6], v[5], v[4], v[3], v[2], v[1], v[0]);
    endfunction

    task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_pulses_low(input string name);
        n_checks++;
        if ({hit_x, hit_y, step_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s: pulses hit=(%b,%b) step=%b, expected all 0", name, hit_x, hit_y, step_done);
        end
    endtask

    initial begin
        logic [25:0] e;

        rst_n = 1'b0; frame_tick = 1'b0; run = 1'b0; speed = '0; frame_div = '0;
        load_valid = 1'b0; load_x = '0; load_y = '0;

        //          rst run spd div ld  lx   ly  tk   expected x,y,dx,dy,hx,hy,step,rdy
        vecs.push_back(mk(0, 0, 0, 0, 0,   0,   0, 0, pack_exp(320, 240, 1, 1, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 1, 1, 0, 0,   0,   0, 0, pack_exp(320, 240, 1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 1, 1, 0, 0,   0,   0, 1, pack_exp(321, 241, 1, 1, 0, 0, 1, 0)));
        vecs.push_back(mk(1, 0, 1, 0, 1, 538, 300, 0, pack_exp(538, 300, 1, 1, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 1, 3, 0, 0,   0,   0, 0, pack_exp(538, 300, 1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 1, 3, 0, 0,   0,   0, 1, pack_exp(540, 303, 0, 1, 1, 0, 1, 0)));
        vecs.push_back(mk(0, 0, 3, 0, 1, 539, 379, 0, pack_exp(540, 303, 0, 1, 0, 0, 0, 1)));
        vecs.push_back(mk(1, 0, 2, 0, 1, 539, 379, 0, pack_exp(539, 379, 1, 1, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 1, 2, 0, 0,   0,   0, 0, pack_exp(539, 379, 1, 1, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 1, 2, 0, 0,   0,   0, 1, pack_exp(540, 380, 0, 0, 1, 1, 1, 0)));
        vecs.push_back(mk(0, 1, 2, 2, 0,   0,   0, 1, pack_exp(540, 380, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 1, 2, 2, 0,   0,   0, 1, pack_exp(540, 380, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 2, 2, 0,   0,   0, 0, pack_exp(540, 380, 0, 0, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 2, 2, 0,   0,   0, 1, pack_exp(540, 380, 0, 0, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 2, 2, 0,   0,   0, 1, pack_exp(540, 380, 0, 0, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 2, 2, 0,   0,   0, 1, pack_exp(540, 380, 0, 0, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 1, 2, 2, 0,   0,   0, 0, pack_exp(540, 380, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 1, 2, 2, 0,   0,   0, 1, pack_exp(538, 378, 0, 0, 0, 0, 1, 0)));
        vecs.push_back(mk(0, 1, 2, 2, 0,   0,   0, 1, pack_exp(538, 378, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 1, 2, 0, 0,   0,   0, 1, pack_exp(536, 376, 0, 0, 0, 0, 1, 0)));
        vecs.push_back(mk(0, 1, 0, 0, 0,   0,   0, 1, pack_exp(536, 376, 0, 0, 0, 0, 1, 0)));
        vecs.push_back(mk(0, 0, 2, 0, 0,   0,   0, 1, pack_exp(534, 374, 0, 0, 0, 0, 1, 1)));
        vecs.push_back(mk(0, 0, 2, 0, 1,  10, 900, 0, pack_exp(100, 380, 0, 0, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 1, 0, 0, 0,   0,   0, 0, pack_exp(100, 380, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 1, 0, 0, 0,   0,   0, 1, pack_exp(100, 380, 1, 0, 1, 0, 1, 0)));
        vecs.push_back(mk(0, 1, 3, 0, 0,   0,   0, 1, pack_exp(103, 377, 1, 0, 0, 0, 1, 0)));

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (vecs[i].rst) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            run        = vecs[i].run;
            speed      = vecs[i].speed;
            frame_div  = vecs[i].div;
            load_valid = vecs[i].ld;
            load_x     = vecs[i].lx;
            load_y     = vecs[i].ly;
            frame_tick = vecs[i].tick;
            sb.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL vec%0d: scoreboard empty", i);
            end else begin
                check($sformatf("vec%0d", i), obs, sb.pop_front());
            end
            @(negedge clk);
            frame_tick = 1'b0;
            load_valid = 1'b0;
            @(posedge clk);
            #1;
            check_pulses_low($sformatf("gap%0d", i));
        end

        // frame_tick held high for three cycles: exactly one step
        @(negedge clk);
        speed = 4'd3; frame_div = 4'd0; run = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        check("held_tick_edge1", obs, pack_exp(106, 374, 1, 0, 0, 0, 1, 0));
        @(posedge clk); #1;
        check("held_tick_edge2", obs, pack_exp(106, 374, 1, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        check("held_tick_edge3", obs, pack_exp(106, 374, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        frame_tick = 1'b0;
        @(posedge clk); #1;

        // reset asserted while a step pulse is showing: clears before any clock edge
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk); #1;
        check("pre_reset_step", obs, pack_exp(109, 371, 1, 0, 0, 0, 1, 0));
        #1;
        rst_n = 1'b0;
        #1;
        e = pack_exp(320, 240, 1, 1, 0, 0, 0, 1);
        check("async_reset_mid_run", obs, e);
        @(negedge clk);
        frame_tick = 1'b0;
        run = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("after_reset_release", obs, e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
